// File: rtl/apb_alu_pkg.sv
// apb_alu_pkg: widths, responder register map and FSM states
// shared by the APB ALU requester and its wait timer.
package apb_alu_pkg;

    localparam int DEF_BITS    = 4;
    localparam int DEF_N       = 2;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;

    localparam int REG_ARG_A  = 0;
    localparam int REG_ARG_B  = 1;
    localparam int REG_OPER   = 2;
    localparam int REG_RESULT = 3;
    localparam int REG_STATUS = 4;

    localparam int LAST_STEP = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    function automatic int step_addr(input logic [2:0] step);
        int a;
        unique case (step)
            3'd0:    a = REG_ARG_A;
            3'd1:    a = REG_ARG_B;
            3'd2:    a = REG_OPER;
            3'd3:    a = REG_RESULT;
            default: a = REG_STATUS;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS wait states of one APB transfer.
// i_clr restarts the count, i_en marks a wait cycle,
// o_timeout flags the wait cycle that reaches TIMEOUT.
module apb_wait_timer
    import apb_alu_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Fires during the TIMEOUT-th wait cycle so the bus drops next cycle.
    assign o_timeout = i_en && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_alu_master.sv
// apb_alu_master: runs one ALU command as five APB transfers
// (write ARG_A, ARG_B, OPER; read RESULT, STATUS) and returns
// the result. Ports: i_cmd_* command in, o_rsp_* response out,
// o_p*/i_p* APB requester.
module apb_alu_master
    import apb_alu_pkg::*;
#(
    parameter int BITS    = DEF_BITS,
    parameter int N       = DEF_N,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    input  logic [BITS-1:0]   i_cmd_argA,
    input  logic [BITS-1:0]   i_cmd_argB,
    input  logic [N-1:0]      i_cmd_oper,
    output logic              o_cmd_ready,
    output logic              o_rsp_valid,
    output logic [BITS-1:0]   o_rsp_result,
    output logic [3:0]        o_rsp_status,
    output logic              o_rsp_err,
    input  logic              i_rsp_ready,
    output logic              o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [ADDR_W-1:0] o_paddr,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr
);

    state_t          r_state;
    logic [2:0]      r_step;
    logic [BITS-1:0] r_arg_b;
    logic [N-1:0]    r_oper;

    logic              w_timeout;
    logic              w_wait;
    logic              w_clr;
    logic              w_done;
    logic [2:0]        w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic              w_wr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_unused_prdata;

    assign w_unused_prdata = ^i_prdata;

    assign w_wait = (r_state == ST_ACCESS) && !i_pready;
    assign w_clr  = (r_state != ST_ACCESS);

    apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_clr),
        .i_en     (w_wait),
        .o_timeout(w_timeout)
    );

    // Step whose transfer is loaded on the next SETUP.
    assign w_sel = (r_state == ST_IDLE) ? 3'd0 : r_step + 3'd1;

    // ARG_A is only sent from IDLE, so it goes straight to o_pwdata.
    always_comb begin
        w_addr  = ADDR_W'(step_addr(w_sel));
        w_wr    = 1'b0;
        w_wdata = '0;
        unique case (w_sel)
            3'd0: begin
                w_wr    = 1'b1;
                w_wdata = DATA_W'(i_cmd_argA);
            end
            3'd1: begin
                w_wr    = 1'b1;
                w_wdata = DATA_W'(r_arg_b);
            end
            3'd2: begin
                w_wr    = 1'b1;
                w_wdata = DATA_W'(r_oper);
            end
            default: ;
        endcase
    end

    assign w_done = w_timeout
                 || (i_pready && (i_pslverr
                 || r_step == 3'(LAST_STEP)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_step       <= 3'd0;
            r_arg_b      <= '0;
            r_oper       <= '0;
            o_cmd_ready  <= 1'b1;
            o_rsp_valid  <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_status <= '0;
            o_rsp_err    <= 1'b0;
            o_psel       <= 1'b0;
            o_penable    <= 1'b0;
            o_pwrite     <= 1'b0;
            o_paddr      <= '0;
            o_pwdata     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_arg_b      <= i_cmd_argB;
                        r_oper       <= i_cmd_oper;
                        r_step       <= 3'd0;
                        o_cmd_ready  <= 1'b0;
                        o_rsp_result <= '0;
                        o_rsp_status <= '0;
                        o_rsp_err    <= 1'b0;
                        o_psel       <= 1'b1;
                        o_penable    <= 1'b0;
                        o_pwrite     <= w_wr;
                        o_paddr      <= w_addr;
                        o_pwdata     <= w_wdata;
                        r_state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    o_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        o_psel      <= 1'b0;
                        o_penable   <= 1'b0;
                        o_pwrite    <= 1'b0;
                        o_paddr     <= '0;
                        o_pwdata    <= '0;
                        o_rsp_valid <= 1'b1;
                        r_step      <= 3'd0;
                        r_state     <= ST_RESP;
                        if (w_timeout || i_pslverr) begin
                            o_rsp_err <= 1'b1;
                        end else begin
                            o_rsp_status <= i_prdata[3:0];
                        end
                    end else if (i_pready) begin
                        if (r_step == 3'(REG_RESULT)) begin
                            o_rsp_result <= i_prdata[BITS-1:0];
                        end
                        r_step    <= w_sel;
                        o_penable <= 1'b0;
                        o_pwrite  <= w_wr;
                        o_paddr   <= w_addr;
                        o_pwdata  <= w_wdata;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_alu_master.sv
// tb_apb_alu_master: randomized scoreboard bench with an APB ALU
// responder model and a response monitor.
module tb_apb_alu_master;

    localparam int BITS    = 4;
    localparam int N       = 2;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [BITS-1:0]   arg_a, arg_b;
    logic [N-1:0]      oper;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [BITS-1:0]   rsp_result;
    logic [3:0]        rsp_status;
    logic              rsp_err;
    logic              rsp_ready;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata, prdata;
    logic              pready, pslverr;

    apb_alu_master #(
        .BITS(BITS), .N(N), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .i_cmd_argA(arg_a),
        .i_cmd_argB(arg_b), .i_cmd_oper(oper),
        .o_cmd_ready(cmd_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_result(rsp_result),
        .o_rsp_status(rsp_status), .o_rsp_err(rsp_err),
        .i_rsp_ready(rsp_ready),
        .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
        .o_paddr(paddr), .o_pwdata(pwdata), .i_prdata(prdata),
        .i_pready(pready), .i_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int st;
        int err;
        int lat;
    } exp_t;

    typedef struct {
        int addr;
        int wr;
        int data;
    } xfer_t;

    exp_t  exp_q[$];
    xfer_t xq[$];

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int cfg_wait[5];
    int cfg_err[5];
    int tw[5];
    int hold_req = 0;
    int mem[3];

    task automatic check(string name, int act, int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Responder ALU: 0 AND, 1 ADD, 2 SUB, 3 XOR, all mod 16.
    function automatic int m_result(int a, int b, int op);
        case (op)
            0: return a & b;
            1: return (a + b) % 16;
            2: return (a - b + 16) % 16;
            default: return a ^ b;
        endcase
    endfunction

    // STATUS: bit0 zero result, bit1 carry (ADD) / borrow (SUB).
    function automatic int m_status(int a, int b, int op);
        int z, c;
        z = (m_result(a, b, op) == 0) ? 1 : 0;
        c = 0;
        if (op == 1 && a + b > 15) c = 1;
        if (op == 2 && a < b) c = 1;
        return 2 * c + z;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : responder
        int in_acc, s_addr, s_wr, s_data, wcnt, idx;
        xfer_t x;
        logic [DATA_W-1:0] rd;
        in_acc = 0;
        wcnt = 0;
        pready = 1'b0;
        pslverr = 1'b0;
        prdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_acc = 0;
                pready = 1'b0;
                pslverr = 1'b0;
            end else if (psel && penable) begin
                if (in_acc == 0) begin
                    in_acc = 1;
                    wcnt = 0;
                    s_addr = int'(paddr);
                    s_wr = int'(pwrite);
                    s_data = int'(pwdata);
                end else begin
                    check("paddr_stable", int'(paddr), s_addr);
                    check("pwrite_stable", int'(pwrite), s_wr);
                    check("pwdata_stable", int'(pwdata), s_data);
                end
                idx = (int'(paddr) <= 4) ? int'(paddr) : 4;
                if (wcnt < cfg_wait[idx]) begin
                    pready = 1'b0;
                    pslverr = 1'b0;
                    wcnt++;
                end else begin
                    pready = 1'b1;
                    pslverr = cfg_err[idx][0];
                    if (xq.size() == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL xfer_extra: addr %0d, required none",
                                 paddr);
                    end else begin
                        x = xq.pop_front();
                        check("xfer_addr", int'(paddr), x.addr);
                        check("xfer_write", int'(pwrite), x.wr);
                        if (x.wr != 0)
                            check("xfer_wdata", int'(pwdata), x.data);
                    end
                    if (pwrite && cfg_err[idx] == 0 && idx < 3)
                        mem[idx] = int'(pwdata);
                    rd = DATA_W'($urandom);
                    if (idx == 3)
                        rd[3:0] = 4'(m_result(mem[0], mem[1], mem[2]));
                    if (idx == 4)
                        rd[3:0] = 4'(m_status(mem[0], mem[1], mem[2]));
                    prdata = rd;
                end
            end else begin
                in_acc = 0;
                pready = 1'b0;
                pslverr = 1'b0;
                prdata = DATA_W'($urandom);
            end
        end
    end

    initial begin : rsp_driver
        int hcnt;
        hcnt = 0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (hold_req != 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) begin
                    hcnt++;
                    if (hcnt >= 5) begin
                        hold_req = 0;
                        hcnt = 0;
                    end
                end
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : monitor
        int prev_valid, rsp_done;
        exp_t e;
        prev_valid = 0;
        rsp_done = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_rsp_valid", int'(rsp_valid), 0);
                check("rst_cmd_ready", int'(cmd_ready), 1);
                prev_valid = 0;
                rsp_done = 0;
            end else begin
                if (rsp_done != 0) begin
                    check("cmd_ready_after_rsp", int'(cmd_ready), 1);
                    rsp_done = 0;
                end
                if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
                if (rsp_valid) begin
                    check("cmd_ready_in_resp", int'(cmd_ready), 0);
                    if (exp_q.size() == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL rsp_extra: valid 1, required 0");
                    end else begin
                        e = exp_q[0];
                        check("rsp_result", int'(rsp_result), e.res);
                        check("rsp_status", int'(rsp_status), e.st);
                        check("rsp_err", int'(rsp_err), e.err);
                        if (prev_valid == 0)
                            check("latency", cyc - acc_cyc, e.lat);
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            rsp_done = 1;
                        end
                    end
                end
                prev_valid = int'(rsp_valid);
            end
        end
    end

    task automatic set_waits(int w0, int w1, int w2, int w3, int w4);
        tw[0] = w0;
        tw[1] = w1;
        tw[2] = w2;
        tw[3] = w3;
        tw[4] = w4;
    endtask

    // es: step answered with PSLVERR, ts: step left hanging; -1 none.
    task automatic issue(int a, int b, int op, int es, int ts);
        int n;
        exp_t e;
        xfer_t x;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("accept_wait", int'(cmd_ready), 1);
        if (!cmd_ready) return;
        e.res = 0;
        e.st = 0;
        e.err = 0;
        e.lat = 0;
        for (int s = 0; s < 5; s++) begin
            cfg_wait[s] = (s == ts) ? TIMEOUT + 20 : tw[s];
            cfg_err[s] = (s == es) ? 1 : 0;
        end
        for (int s = 0; s < 5; s++) begin
            if (s == ts) begin
                e.lat += 1 + TIMEOUT;
                e.err = 1;
                break;
            end
            x.addr = s;
            x.wr = (s < 3) ? 1 : 0;
            x.data = (s == 0) ? a : (s == 1) ? b : (s == 2) ? op : 0;
            xq.push_back(x);
            e.lat += 2 + tw[s];
            if (s == es) begin
                e.err = 1;
                break;
            end
            if (s == 3) e.res = m_result(a, b, op);
            if (s == 4) e.st = m_status(a, b, op);
        end
        exp_q.push_back(e);
        arg_a = BITS'(a);
        arg_b = BITS'(b);
        oper = N'(op);
        cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        arg_a = BITS'($urandom);
        arg_b = BITS'($urandom);
        oper = N'($urandom);
    endtask

    task automatic mid_reset();
        int n;
        n = 0;
        @(negedge clk);
        while (!(psel && penable && paddr == 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_reach_argb", int'(psel && penable && paddr == 1), 1);
        #1 rst = 1'b1;
        #1;
        check("areset_psel", int'(psel), 0);
        check("areset_penable", int'(penable), 0);
        check("areset_cmd_ready", int'(cmd_ready), 1);
        exp_q.delete();
        xq.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("post_reset_cmd_ready", int'(cmd_ready), 1);
    endtask

    initial begin : stimulus
        int n, r, es, ts;
        rst = 1'b1;
        cmd_valid = 1'b0;
        arg_a = '0;
        arg_b = '0;
        oper = '0;
        for (int s = 0; s < 5; s++) begin
            cfg_wait[s] = 0;
            cfg_err[s] = 0;
        end
        for (int s = 0; s < 3; s++) mem[s] = 0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_psel", int'(psel), 0);
        check("reset_penable", int'(penable), 0);
        check("reset_paddr", int'(paddr), 0);
        check("reset_pwdata", int'(pwdata), 0);
        check("reset_rsp_err", int'(rsp_err), 0);
        check("reset_rsp_result", int'(rsp_result), 0);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #2;

        set_waits(0, 0, 0, 0, 0);
        issue(2, 1, 1, -1, -1);
        set_waits(0, 0, 0, 3, 0);
        issue(2, 1, 1, -1, -1);
        set_waits(0, 0, 0, 0, 0);
        issue(2, 1, 1, 1, -1);
        issue(2, 1, 1, -1, 2);
        issue(5, 7, 1, -1, -1);
        set_waits(0, 0, 0, 0, TIMEOUT - 1);
        issue(12, 9, 2, -1, -1);
        set_waits(0, 0, 0, 0, 0);
        issue(12, 9, 2, -1, 3);
        hold_req = 1;
        issue(9, 3, 2, -1, -1);
        issue(15, 15, 1, 3, -1);
        issue(6, 10, 3, 4, -1);
        issue(0, 0, 0, -1, -1);

        set_waits(0, 4, 0, 0, 0);
        issue(3, 4, 1, -1, -1);
        mid_reset();
        set_waits(0, 0, 1, 0, 0);
        issue(8, 8, 1, -1, -1);

        for (int k = 0; k < 40; k++) begin
            set_waits($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3));
            r = $urandom_range(0, 11);
            es = (r == 0) ? $urandom_range(0, 4) : -1;
            ts = (r == 1) ? $urandom_range(0, 4) : -1;
            issue($urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 3), es, ts);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_rsp", exp_q.size(), 0);
        check("drain_xfer", xq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/apb_alu_master.md
APB_ALU_MASTER -- requirements
Module: apb_alu_master

Interface
REQ-001 Parameter BITS, default 4, ALU operand/result width.
REQ-002 Parameter N, default 2, ALU opcode width.
REQ-003 Parameter ADDR_W, default 4, APB address width.
REQ-004 Parameter DATA_W, default 8, APB data width; BITS <= DATA_W and N <= DATA_W.
REQ-005 Parameter TIMEOUT, default 15, max ACCESS cycles waiting for i_pready.
REQ-006 Ports, one per line: i_clk  in  1  the single clock, rising edge; one clock, no other clock domain.
REQ-007 i_rst  in  1  reset, asynchronous and active-high.
REQ-008 i_cmd_valid  in  1  command request; i_cmd_argA/i_cmd_argB  in  BITS  operands; i_cmd_oper  in  N  opcode.
REQ-009 o_cmd_ready  out  1  command accepted on the cycle where i_cmd_valid and o_cmd_ready are both 1.
REQ-010 o_rsp_valid  out  1; o_rsp_result  out  BITS; o_rsp_status  out  4; o_rsp_err  out  1; i_rsp_ready  in  1.
REQ-011 APB requester ports: o_psel, o_penable, o_pwrite  out  1; o_paddr  out  ADDR_W; o_pwdata  out  DATA_W; i_prdata  in  DATA_W; i_pready, i_pslverr  in  1.

Function
REQ-012 Register map of the ALU responder: 0x0 ARG_A (W), 0x1 ARG_B (W), 0x2 OPER (W, starts the operation), 0x3 RESULT (R, bits BITS-1:0), 0x4 STATUS (R, bits 3:0).
REQ-013 An accepted command runs 5 APB transfers in fixed order: write 0x0, write 0x1, write 0x2, read 0x3, read 0x4.
REQ-014 Write data is zero-extended to DATA_W; read data is truncated (RESULT to BITS, STATUS to 4).
REQ-015 FSM states: IDLE, SETUP, ACCESS, RESP; a 3-bit step counter 0..4 selects address, direction and data.
REQ-016 IDLE: o_cmd_ready=1, all APB outputs 0; on handshake, latch the operands, set step=0, go to SETUP.
REQ-017 SETUP (exactly 1 cycle): o_psel=1, o_penable=0, paddr/pwrite/pwdata valid; next state ACCESS.
REQ-018 ACCESS: o_psel=1, o_penable=1; paddr/pwrite/pwdata stay stable until the cycle where i_pready=1.
REQ-019 ACCESS with i_pready=1 and i_pslverr=0: capture i_prdata on reads; at step<4 increment step and go to SETUP; at step=4 go to RESP.
REQ-020 ACCESS with i_pready=1 and i_pslverr=1: abort the remaining steps, set err=1, go to RESP.
REQ-021 Wait counter resets at each SETUP and counts ACCESS cycles with i_pready=0; on reaching TIMEOUT, deassert psel/penable next cycle, set err=1, go to RESP.
REQ-022 Min latency, accept to o_rsp_valid: 10 cycles (5 x 2); each wait state adds 1 cycle.
REQ-023 RESP: o_rsp_valid=1; result/status/err are held stable until i_rsp_ready=1, then go to IDLE.
REQ-024 On err, o_rsp_result and o_rsp_status are the values captured so far (0 if not read).
REQ-025 o_cmd_ready=0 in every state except IDLE; no command is queued.
REQ-026 o_psel and o_penable never toggle between transfers: both return to 0 for at least the RESP/IDLE cycle, except that SETUP follows ACCESS directly within a command.

Reset
REQ-027 i_rst=1 asynchronously forces IDLE, step=0, wait counter=0, and all outputs 0 except o_cmd_ready=1.
REQ-028 Reset during SETUP/ACCESS drops o_psel/o_penable immediately; the aborted command produces no response.

Structure
REQ-029 A shared package apb_alu_pkg holds the register address constants, the state enum, and the default widths.
REQ-030 One sub-module, apb_wait_timer (wait counter + timeout flag), is natural; everything else is flat.

Verification
REQ-031 Reset, then cmd argA=2, argB=1, oper=01; responder i_pready=1, returns RESULT=3, STATUS=0 -> writes 0x0=2, 0x1=1, 0x2=1, then 2 reads; rsp result=3, status=0, err=0; o_rsp_valid rises 10 cycles after accept.
REQ-032 Same command with i_pready low for 3 cycles on the RESULT read -> response at cycle 13, paddr=0x3 stable throughout ACCESS.
REQ-033 i_pslverr=1 on the ARG_B write -> no transfer to 0x2/0x3/0x4; rsp err=1, result=0, status=0.
REQ-034 i_pready held 0 on OPER write -> after 15 ACCESS cycles psel drops; rsp err=1; next command completes normally.
REQ-035 i_rsp_ready held 0 for 5 cycles -> rsp fields stable, o_cmd_ready=0; accept occurs the cycle after i_rsp_ready=1.
REQ-036 i_rst pulsed mid-ACCESS of the ARG_B write -> psel/penable=0 asynchronously, no o_rsp_valid, o_cmd_ready=1 after release.
